// File: rtl/bp_pkg.sv
// Shared constants and counter helpers for the branch history table.
package bp_pkg;

    localparam int MODE_BIMODAL = 0;
    localparam int MODE_GSHARE  = 1;

    // Weakly not-taken: one below the taken threshold.
    function automatic logic [3:0] ctr_init(input int ctr_bits);
        return 4'((1 << (ctr_bits - 1)) - 1);
    endfunction

    function automatic logic [3:0] sat_step(input logic [3:0] ctr, input logic up,
                                            input int ctr_bits);
        logic [3:0] max;
        max = 4'((1 << ctr_bits) - 1);
        if (up)
            return (ctr == max) ? ctr : ctr + 4'd1;
        return (ctr == 4'd0) ? ctr : ctr - 4'd1;
    endfunction

endpackage

// File: rtl/branch_pred_table_if.sv
// DEC lookup, EX resolution and statistics signals of the branch history table.
interface branch_pred_table_if #(
    parameter int XLEN     = 32,
    parameter int IDX_W    = 4,
    parameter int GHR_BITS = 4,
    parameter int STAT_W   = 32
);
    logic                stall;
    logic [XLEN-1:0]     pred_pc;
    logic                pred_taken;
    logic [IDX_W-1:0]    pred_idx;
    logic                upd_en;
    logic [IDX_W-1:0]    upd_idx;
    logic                upd_taken;
    logic                upd_mispred;
    logic [GHR_BITS-1:0] ghr;
    logic [STAT_W-1:0]   stat_branch;
    logic [STAT_W-1:0]   stat_mispred;

    modport master (
        output stall, pred_pc, upd_en, upd_idx, upd_taken, upd_mispred,
        input  pred_taken, pred_idx, ghr, stat_branch, stat_mispred
    );

    modport slave (
        input  stall, pred_pc, upd_en, upd_idx, upd_taken, upd_mispred,
        output pred_taken, pred_idx, ghr, stat_branch, stat_mispred
    );
endinterface

// File: rtl/bp_stat_counter.sv
// Saturating event counter with asynchronous active-low clear.
module bp_stat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_cnt <= '0;
        else if (i_inc && !(&r_cnt))
            r_cnt <= r_cnt + W'(1);
    end

    assign o_cnt = r_cnt;
endmodule

// File: rtl/branch_pred_table.sv
// PC-indexed saturating-counter branch predictor (bimodal or gshare) with statistics.
module branch_pred_table
    import bp_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ENTRIES  = 16,
    parameter int CTR_BITS = 2,
    parameter int MODE     = MODE_BIMODAL,
    parameter int GHR_BITS = 4,
    parameter int STAT_W   = 32,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    branch_pred_table_if.slave   bus
);
    if (ENTRIES < 2 || (ENTRIES & (ENTRIES - 1)) != 0) begin : g_bad_entries
        $error("branch_pred_table: ENTRIES must be a power of two >= 2");
    end
    if (CTR_BITS < 1 || CTR_BITS > 4) begin : g_bad_ctr
        $error("branch_pred_table: CTR_BITS must be 1..4");
    end
    if (GHR_BITS < 1 || GHR_BITS > IDX_W) begin : g_bad_ghr
        $error("branch_pred_table: GHR_BITS must be 1..IDX_W");
    end

    logic                              w_upd;
    logic [IDX_W-1:0]                  w_pc_idx;
    logic [IDX_W-1:0]                  w_idx;
    logic [ENTRIES-1:0][CTR_BITS-1:0]  w_table;
    logic [GHR_BITS-1:0]               r_ghr;
    logic                              w_unused_pc;

    assign w_upd       = bus.upd_en && !bus.stall;
    assign w_pc_idx    = bus.pred_pc[IDX_W+1:2];
    assign w_unused_pc = ^{bus.pred_pc[XLEN-1:IDX_W+2], bus.pred_pc[1:0]};
    assign w_idx       = (MODE == MODE_GSHARE) ? (w_pc_idx ^ IDX_W'(r_ghr)) : w_pc_idx;

    // No bypass: lookup always sees the pre-edge counter and history.
    assign bus.pred_idx   = w_idx;
    assign bus.pred_taken = w_table[w_idx][CTR_BITS-1];
    assign bus.ghr        = r_ghr;

    for (genvar e = 0; e < ENTRIES; e++) begin : g_ent
        logic [CTR_BITS-1:0] r_ctr;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)
                r_ctr <= CTR_BITS'(ctr_init(CTR_BITS));
            else if (w_upd && bus.upd_idx == IDX_W'(e))
                r_ctr <= CTR_BITS'(sat_step(4'(r_ctr), bus.upd_taken, CTR_BITS));
        end

        assign w_table[e] = r_ctr;
    end

    // History only tracks resolved outcomes; bimodal keeps it at zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_ghr <= '0;
        else if (w_upd && MODE == MODE_GSHARE)
            r_ghr <= (r_ghr << 1) | GHR_BITS'(bus.upd_taken);
    end

    bp_stat_counter #(.W(STAT_W)) u_stat_branch (
        .clk     (clk),
        .reset_n (reset_n),
        .i_inc   (w_upd),
        .o_cnt   (bus.stat_branch)
    );

    bp_stat_counter #(.W(STAT_W)) u_stat_mispred (
        .clk     (clk),
        .reset_n (reset_n),
        .i_inc   (w_upd && bus.upd_mispred),
        .o_cnt   (bus.stat_mispred)
    );
endmodule

// File: tb/tb_branch_pred_table.sv
// Directed bench: bimodal 2-bit, 1-bit with narrow stats, and gshare instances.
module tb_branch_pred_table;
    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    branch_pred_table_if #(.XLEN(32), .IDX_W(4), .GHR_BITS(4), .STAT_W(32)) bus0 ();
    branch_pred_table_if #(.XLEN(32), .IDX_W(4), .GHR_BITS(4), .STAT_W(3))  bus1 ();
    branch_pred_table_if #(.XLEN(32), .IDX_W(4), .GHR_BITS(4), .STAT_W(32)) bus2 ();

    branch_pred_table u0 (.clk(clk), .reset_n(reset_n), .bus(bus0.slave));
    branch_pred_table #(.CTR_BITS(1), .STAT_W(3)) u1 (.clk(clk), .reset_n(reset_n), .bus(bus1.slave));
    branch_pred_table #(.MODE(1), .GHR_BITS(4)) u2 (.clk(clk), .reset_n(reset_n), .bus(bus2.slave));

    logic [31:0] sb_q[$];
    int n_tot  = 0;
    int n_pass = 0;

    task automatic expect_v(input logic [31:0] v);
        sb_q.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] exp_v;
        n_tot++;
        if (sb_q.size() == 0) begin
            $error("FAIL %s: observed %0h, no expected value queued", tag, obs);
        end else begin
            exp_v = sb_q.pop_front();
            assert (obs === exp_v) n_pass++;
            else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic upd0(input logic [3:0] idx, input logic t, input logic m);
        @(negedge clk);
        bus0.upd_en = 1'b1; bus0.upd_idx = idx; bus0.upd_taken = t; bus0.upd_mispred = m;
        @(posedge clk); #1;
        bus0.upd_en = 1'b0; bus0.upd_mispred = 1'b0;
    endtask

    task automatic upd1(input logic [3:0] idx, input logic t, input logic m);
        @(negedge clk);
        bus1.upd_en = 1'b1; bus1.upd_idx = idx; bus1.upd_taken = t; bus1.upd_mispred = m;
        @(posedge clk); #1;
        bus1.upd_en = 1'b0; bus1.upd_mispred = 1'b0;
    endtask

    task automatic upd2(input logic [3:0] idx, input logic t, input logic m);
        @(negedge clk);
        bus2.upd_en = 1'b1; bus2.upd_idx = idx; bus2.upd_taken = t; bus2.upd_mispred = m;
        @(posedge clk); #1;
        bus2.upd_en = 1'b0; bus2.upd_mispred = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        bus0.stall = 0; bus0.pred_pc = 0; bus0.upd_en = 0; bus0.upd_idx = 0; bus0.upd_taken = 0; bus0.upd_mispred = 0;
        bus1.stall = 0; bus1.pred_pc = 0; bus1.upd_en = 0; bus1.upd_idx = 0; bus1.upd_taken = 0; bus1.upd_mispred = 0;
        bus2.stall = 0; bus2.pred_pc = 0; bus2.upd_en = 0; bus2.upd_idx = 0; bus2.upd_taken = 0; bus2.upd_mispred = 0;
        #1;

        // Reset state: weakly not-taken everywhere, history and stats cleared.
        for (int pc = 0; pc <= 32'h3C; pc += 4) begin
            bus0.pred_pc = 32'(pc); bus2.pred_pc = 32'(pc); #1;
            expect_v(0); chk($sformatf("rst_pred0_%0h", pc), 32'(bus0.pred_taken));
            expect_v(0); chk($sformatf("rst_pred2_%0h", pc), 32'(bus2.pred_taken));
        end
        expect_v(0); chk("rst_ghr2", 32'(bus2.ghr));
        expect_v(0); chk("rst_stat_br", bus0.stat_branch);
        expect_v(0); chk("rst_stat_mp", bus0.stat_mispred);

        @(negedge clk); reset_n = 1'b1;

        // Train idx 3: 01 -> 10 -> 11 -> 10 -> 01.
        bus0.pred_pc = 32'h0C; #1;
        expect_v(0); chk("train_init", 32'(bus0.pred_taken));
        upd0(4'd3, 1'b1, 1'b1); expect_v(1); chk("train_t1", 32'(bus0.pred_taken));
        upd0(4'd3, 1'b1, 1'b0); expect_v(1); chk("train_t2", 32'(bus0.pred_taken));
        upd0(4'd3, 1'b0, 1'b1); expect_v(1); chk("train_n1", 32'(bus0.pred_taken));
        upd0(4'd3, 1'b0, 1'b1); expect_v(0); chk("train_n2", 32'(bus0.pred_taken));
        expect_v(4); chk("train_stat_br", bus0.stat_branch);
        expect_v(3); chk("train_stat_mp", bus0.stat_mispred);

        // Saturation at the top: five takens then one not-taken stays taken.
        bus0.pred_pc = 32'h1C;
        for (int i = 0; i < 5; i++) upd0(4'd7, 1'b1, 1'b0);
        expect_v(1); chk("sat_top", 32'(bus0.pred_taken));
        upd0(4'd7, 1'b0, 1'b0);
        expect_v(1); chk("sat_dec", 32'(bus0.pred_taken));
        expect_v(10); chk("sat_stat_br", bus0.stat_branch);

        // Mispredict flag without upd_en is ignored.
        @(negedge clk); bus0.upd_mispred = 1'b1;
        @(posedge clk); #1; bus0.upd_mispred = 1'b0;
        expect_v(10); chk("mp_noen_br", bus0.stat_branch);
        expect_v(3);  chk("mp_noen_mp", bus0.stat_mispred);

        // 1-bit counters with 3-bit stats.
        bus1.pred_pc = 32'h1C;
        upd1(4'd7, 1'b1, 1'b1); expect_v(1); chk("c1_t1", 32'(bus1.pred_taken));
        upd1(4'd7, 1'b1, 1'b1); expect_v(1); chk("c1_sat", 32'(bus1.pred_taken));
        upd1(4'd7, 1'b0, 1'b1); expect_v(0); chk("c1_n1", 32'(bus1.pred_taken));
        for (int i = 0; i < 6; i++) upd1(4'd7, 1'b0, 1'b1);
        expect_v(0); chk("c1_floor", 32'(bus1.pred_taken));
        expect_v(7); chk("c1_stat_br_sat", 32'(bus1.stat_branch));
        expect_v(7); chk("c1_stat_mp_sat", 32'(bus1.stat_mispred));

        // Same-cycle lookup/update of idx 5: old value until the edge.
        @(negedge clk);
        bus0.pred_pc = 32'h14;
        bus0.upd_en = 1'b1; bus0.upd_idx = 4'd5; bus0.upd_taken = 1'b1; bus0.upd_mispred = 1'b1;
        #1; expect_v(0); chk("same_cyc_pre", 32'(bus0.pred_taken));
        @(posedge clk); #1;
        bus0.upd_en = 1'b0; bus0.upd_mispred = 1'b0;
        expect_v(1); chk("same_cyc_post", 32'(bus0.pred_taken));
        expect_v(5); chk("bim_idx", 32'(bus0.pred_idx));
        expect_v(0); chk("bim_ghr", 32'(bus0.ghr));

        // Gshare history and index folding.
        upd2(4'd0, 1'b1, 1'b0);
        expect_v(1); chk("gs_ghr1", 32'(bus2.ghr));
        for (int i = 0; i < 3; i++) upd2(4'd0, 1'b1, 1'b0);
        expect_v(4'hF); chk("gs_ghrF", 32'(bus2.ghr));
        bus2.pred_pc = 32'h00; #1;
        expect_v(4'hF); chk("gs_idx_00", 32'(bus2.pred_idx));
        bus2.pred_pc = 32'h3C; #1;
        expect_v(4'h0); chk("gs_idx_3c", 32'(bus2.pred_idx));
        @(negedge clk);
        bus2.pred_pc = 32'h00;
        bus2.upd_en = 1'b1; bus2.upd_idx = 4'd1; bus2.upd_taken = 1'b0;
        #1; expect_v(4'hF); chk("gs_same_pre", 32'(bus2.pred_idx));
        @(posedge clk); #1; bus2.upd_en = 1'b0;
        expect_v(4'hE); chk("gs_same_post", 32'(bus2.pred_idx));

        // Stall freezes table, history and stats.
        bus0.stall = 1'b1; bus2.stall = 1'b1;
        upd0(4'd3, 1'b1, 1'b1);
        upd2(4'd0, 1'b1, 1'b1);
        bus0.pred_pc = 32'h0C; #1;
        expect_v(0);    chk("stall_pred", 32'(bus0.pred_taken));
        expect_v(11);   chk("stall_stat_br", bus0.stat_branch);
        expect_v(4);    chk("stall_stat_mp", bus0.stat_mispred);
        expect_v(4'hE); chk("stall_ghr", 32'(bus2.ghr));
        bus0.stall = 1'b0; bus2.stall = 1'b0;

        // Asynchronous reset in the middle of a pending update.
        @(negedge clk);
        bus0.pred_pc = 32'h14;
        bus0.upd_en = 1'b1; bus0.upd_idx = 4'd5; bus0.upd_taken = 1'b1;
        bus2.upd_en = 1'b1; bus2.upd_idx = 4'd2; bus2.upd_taken = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        expect_v(0); chk("arst_pred", 32'(bus0.pred_taken));
        expect_v(0); chk("arst_stat_br", bus0.stat_branch);
        expect_v(0); chk("arst_stat_mp", bus0.stat_mispred);
        expect_v(0); chk("arst_ghr", 32'(bus2.ghr));
        expect_v(0); chk("arst_c1_br", 32'(bus1.stat_branch));
        @(posedge clk); #1;
        expect_v(0); chk("arst_hold_pred", 32'(bus0.pred_taken));
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        bus0.upd_en = 1'b0; bus2.upd_en = 1'b0;
        expect_v(1); chk("rel_first_upd", 32'(bus0.pred_taken));
        expect_v(1); chk("rel_stat_br", bus0.stat_branch);
        expect_v(1); chk("rel_ghr", 32'(bus2.ghr));

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
